emif_burst_responder: RTL and testbench

Single-clock Avalon-MM burst responder that terminates the EMIF read and write master ports driven by the line buffer. It is backed by on-chip RAM and replaces the external-memory EMIF on builds without DDR and in simulation. It accepts 256-bit bursts, arbitrates one burst at a time between the read and write ports, and returns read data in order with a fixed RAM latency.

---
 rtl/emif_burst_responder.sv | 158 +++++++++++++++
 tb/tb_emif_burst_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/emif_burst_responder.sv
// emif_burst_responder: Avalon-MM burst slave that terminates the line buffer's
// EMIF read/write masters on on-chip RAM. One burst in service at a time,
// round-robin between ports on collision, in-order read return at a fixed latency.
module emif_burst_responder #(
   parameter int         MEM_AW     = 12,
   parameter int         RD_LATENCY = 2,
   parameter logic [2:0] BASE_SEL   = 3'b001,
   parameter int         MAX_BURST  = 32
) (
   input  logic         emif_br_clk,
   input  logic         emif_br_reset,
   input  logic [27:0]  emif_rd_addr,
   input  logic         emif_rd_read,
   input  logic [5:0]   emif_rd_burstcount,
   output logic         emif_rd_waitrequest,
   output logic [255:0] emif_rd_rdata,
   output logic         emif_rd_readdatavalid,
   input  logic [27:0]  emif_wr_addr,
   input  logic         emif_wr_write,
   input  logic [255:0] emif_wr_wdata,
   input  logic [5:0]   emif_wr_burstcount,
   output logic         emif_wr_waitrequest,
   output logic         err_o
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] WR_BURST = 2'd1;
   localparam logic [1:0] RD_ISSUE = 2'd2;
   localparam logic       RR_WRITE = 1'b0;
   localparam logic       RR_READ  = 1'b1;
   localparam logic [5:0] MAX_BC   = 6'(MAX_BURST);

   logic [255:0]      ram [0:(1<<MEM_AW)-1];
   logic [1:0]        state;
   logic              rr_last;
   logic              win_q;
   logic              err_q;
   logic [MEM_AW-1:0] idx_q;
   logic [5:0]        beats_left;
   logic [RD_LATENCY:0] vld_pipe;
   logic [255:0]      dat_pipe [1:RD_LATENCY];

   logic              grant_wr, grant_rd, issue, wr_en;
   logic              wr_win, rd_win, wr_bad, rd_bad;
   logic [5:0]        wr_bc, rd_bc;
   logic [MEM_AW-1:0] wr_idx;
   logic              unused_bits;

   // Zero-length bursts become one beat, oversize bursts are cut to MAX_BURST.
   function automatic logic [5:0] clamp_bc(input logic [5:0] bc);
      if (bc == 6'd0)       return 6'd1;
      else if (bc > MAX_BC) return MAX_BC;
      else                  return bc;
   endfunction

   assign wr_bc  = clamp_bc(emif_wr_burstcount);
   assign rd_bc  = clamp_bc(emif_rd_burstcount);
   assign wr_bad = (emif_wr_burstcount == 6'd0) || (emif_wr_burstcount > MAX_BC);
   assign rd_bad = (emif_rd_burstcount == 6'd0) || (emif_rd_burstcount > MAX_BC);
   assign wr_win = (emif_wr_addr[27:25] == BASE_SEL);
   assign rd_win = (emif_rd_addr[27:25] == BASE_SEL);

   // Only part of each address selects a RAM word; the rest is deliberately ignored.
   assign unused_bits = ^{emif_rd_addr, emif_wr_addr};

   // Grant arbitration in IDLE: single requester wins, a collision goes to the port not served last.
   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (!emif_br_reset && state == IDLE) begin
         if (emif_wr_write && emif_rd_read) begin
            grant_wr = (rr_last == RR_READ);
            grant_rd = (rr_last == RR_WRITE);
         end else begin
            grant_wr = emif_wr_write;
            grant_rd = emif_rd_read;
         end
      end
   end

   // Reset forces both waitrequests high so nothing is accepted in the reset cycle.
   assign emif_wr_waitrequest = !(grant_wr || (!emif_br_reset && state == WR_BURST));
   assign emif_rd_waitrequest = !grant_rd;
   assign issue               = !emif_br_reset && (state == RD_ISSUE);
   assign vld_pipe[0]         = issue;

   // First beat uses the live address; later beats use the latched running index.
   assign wr_idx = (state == IDLE) ? emif_wr_addr[MEM_AW+4:5] : idx_q;
   assign wr_en  = (grant_wr && wr_win) ||
                   (!emif_br_reset && state == WR_BURST && emif_wr_write && win_q);

   // RAM write port; out-of-window beats complete the handshake but never land.
   always_ff @(posedge emif_br_clk) begin
      if (wr_en) ram[wr_idx] <= emif_wr_wdata;
   end

   // Burst FSM: command acceptance, beat counting, index wrap and sticky error.
   always_ff @(posedge emif_br_clk) begin
      if (emif_br_reset) begin
         state      <= IDLE;
         rr_last    <= RR_READ;
         win_q      <= 1'b0;
         err_q      <= 1'b0;
         idx_q      <= '0;
         beats_left <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (emif_wr_write && emif_rd_read)
                  rr_last <= grant_wr ? RR_WRITE : RR_READ;
               if (grant_wr) begin
                  idx_q      <= emif_wr_addr[MEM_AW+4:5] + MEM_AW'(1);
                  beats_left <= wr_bc - 6'd1;
                  win_q      <= wr_win;
                  if (wr_bc != 6'd1) state <= WR_BURST;
                  if (wr_bad || !wr_win) err_q <= 1'b1;
               end else if (grant_rd) begin
                  idx_q      <= emif_rd_addr[MEM_AW+4:5];
                  beats_left <= rd_bc;
                  win_q      <= rd_win;
                  state      <= RD_ISSUE;
                  if (rd_bad || !rd_win) err_q <= 1'b1;
               end
            end
            WR_BURST: begin
               if (emif_wr_write) begin
                  idx_q      <= idx_q + MEM_AW'(1);
                  beats_left <= beats_left - 6'd1;
                  if (beats_left == 6'd1) state <= IDLE;
               end
            end
            RD_ISSUE: begin
               idx_q      <= idx_q + MEM_AW'(1);
               beats_left <= beats_left - 6'd1;
               if (beats_left == 6'd1) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read return pipeline: stage 1 is the RAM read, later stages only delay; reset drops in-flight beats.
   always_ff @(posedge emif_br_clk) begin
      if (emif_br_reset) begin
         vld_pipe[RD_LATENCY:1] <= '0;
         for (int k = 1; k <= RD_LATENCY; k++) dat_pipe[k] <= '0;
      end else begin
         for (int k = 1; k <= RD_LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
         if (issue) dat_pipe[1] <= win_q ? ram[idx_q] : '0;
         for (int k = 2; k <= RD_LATENCY; k++) dat_pipe[k] <= dat_pipe[k-1];
      end
   end

   assign emif_rd_readdatavalid = vld_pipe[RD_LATENCY];
   assign emif_rd_rdata         = dat_pipe[RD_LATENCY];
   assign err_o                 = err_q;

endmodule

// File: tb/tb_emif_burst_responder.sv
// tb_emif_burst_responder: random and directed bursts against a flat word-array
// memory model; expected read beats (data + due cycle) are queued at command
// acceptance and a negedge monitor pops them as readdatavalid arrives.
module tb_emif_burst_responder;
   localparam int         L   = 2;
   localparam logic [27:0] WIN = 28'h200_0000;   // addr[27:25] = 3'b001

   logic         clk = 1'b0, rst = 1'b1;
   logic [27:0]  rd_addr = '0, wr_addr = '0;
   logic         rd_read = 1'b0, wr_write = 1'b0;
   logic [5:0]   rd_bc = '0, wr_bc = '0;
   logic [255:0] wr_wdata = '0;
   logic         rd_wait, wr_wait, rdv, err_o;
   logic [255:0] rdata;

   emif_burst_responder #(.MEM_AW(12), .RD_LATENCY(L), .BASE_SEL(3'b001), .MAX_BURST(32)) dut (
      .emif_br_clk(clk), .emif_br_reset(rst),
      .emif_rd_addr(rd_addr), .emif_rd_read(rd_read), .emif_rd_burstcount(rd_bc),
      .emif_rd_waitrequest(rd_wait), .emif_rd_rdata(rdata), .emif_rd_readdatavalid(rdv),
      .emif_wr_addr(wr_addr), .emif_wr_write(wr_write), .emif_wr_wdata(wr_wdata),
      .emif_wr_burstcount(wr_bc), .emif_wr_waitrequest(wr_wait), .err_o(err_o));

   always #5 clk = ~clk;

   longint       cyc = 0;
   always @(posedge clk) cyc++;

   logic [255:0] mem_m [0:4095];
   logic [255:0] exp_d[$];
   longint       exp_due[$];
   bit           exp_err = 1'b0;
   int           n_chk = 0, n_fail = 0;

   function automatic int eff_bc(input logic [5:0] bc);
      if (bc == 0) return 1;
      if (bc > 32) return 32;
      return int'(bc);
   endfunction

   function automatic bit in_win(input logic [27:0] a);
      return a[27:25] == 3'b001;
   endfunction

   function automatic bit bad_bc(input logic [5:0] bc);
      return (bc == 0) || (bc > 32);
   endfunction

   function automatic logic [255:0] wdat(input int seed, input int k);
      return {32'(seed), 192'(0), 32'((k + 1) * 'h11)};
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Queue the beats a read command will return, due 1 + L cycles after the command cycle.
   task automatic model_rd(input logic [27:0] a, input logic [5:0] bc, input longint c);
      int n   = eff_bc(bc);
      int idx = int'(a[16:5]);
      bit w   = in_win(a);
      for (int i = 0; i < n; i++) begin
         exp_d.push_back(w ? mem_m[(idx + i) & 4095] : 256'(0));
         exp_due.push_back(c + 1 + L + i);
      end
      if (!w || bad_bc(bc)) exp_err = 1'b1;
   endtask

   // Monitor: every readdatavalid must match the oldest queued beat, on its due cycle.
   always @(negedge clk) begin
      if (rdv) begin
         if (exp_d.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_rdv: got data %0h with nothing expected (cycle %0d)", rdata, cyc);
         end else begin
            chk("rd_data", rdata, exp_d.pop_front());
            chk("rd_cycle", 256'(cyc), 256'(exp_due.pop_front()));
         end
      end else if (exp_due.size() > 0 && exp_due[0] <= cyc) begin
         n_chk++; n_fail++;
         $display("FAIL missing_rdv: got no beat expected one due at cycle %0d", exp_due[0]);
         void'(exp_d.pop_front());
         void'(exp_due.pop_front());
      end
   end

   // All tasks start and end just after a posedge.
   task automatic do_write(input logic [27:0] a, input logic [5:0] bc, input int seed);
      int n = eff_bc(bc), idx = int'(a[16:5]), got = 0, guard = 0;
      longint t0 = 0, tl = 0;
      bit w = in_win(a);
      wr_addr = a; wr_bc = bc; wr_write = 1'b1; wr_wdata = wdat(seed, 0);
      while (got < n && guard < 200) begin
         @(negedge clk);
         if (!wr_wait) begin
            if (got == 0) t0 = cyc;
            tl = cyc;
            if (w) mem_m[(idx + got) & 4095] = wr_wdata;
            got++;
         end
         @(posedge clk); #1;
         wr_wdata = wdat(seed, got);
         guard++;
      end
      wr_write = 1'b0;
      chk("wr_beats", 256'(got), 256'(n));
      chk("wr_tput", 256'(tl - t0), 256'(n - 1));
      if (!w || bad_bc(bc)) exp_err = 1'b1;
   endtask

   task automatic do_read(input logic [27:0] a, input logic [5:0] bc);
      int guard = 0;
      bit acc = 1'b0;
      rd_addr = a; rd_bc = bc; rd_read = 1'b1;
      while (!acc && guard < 100) begin
         @(negedge clk);
         if (!rd_wait) begin
            acc = 1'b1;
            model_rd(a, bc, cyc);
         end else begin
            @(posedge clk); #1;
            guard++;
         end
      end
      chk("rd_accept", 256'(acc), 256'(1));
      @(posedge clk); #1;
      rd_read = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while (exp_d.size() > 0 && g < 300) begin
         @(negedge clk); g++;
      end
      chk("drain", 256'(exp_d.size()), 256'(0));
      @(posedge clk); #1;
   endtask

   task automatic chk_err(input string name);
      @(negedge clk);
      chk(name, 256'(err_o), 256'(exp_err));
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      logic [27:0] a;
      logic [5:0]  bc;
      int          seed;
      longint      p;
      for (int i = 0; i < 4096; i++) mem_m[i] = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_waits", 256'({rd_wait, wr_wait}), 256'(2'b11));
      chk("rst_rdv", 256'(rdv), 256'(0));
      chk("rst_rdata", rdata, 256'(0));
      chk("rst_err", 256'(err_o), 256'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      // Collision right after reset: write first, then read, then a second collision goes to read.
      wr_addr = WIN | 28'h400; wr_bc = 6'd1; wr_wdata = wdat(7, 0); wr_write = 1'b1;
      rd_addr = WIN | 28'h400; rd_bc = 6'd1; rd_read = 1'b1;
      @(negedge clk);
      chk("coll1_grant", 256'({rd_wait, wr_wait}), 256'(2'b10));
      mem_m[32] = wr_wdata;
      @(posedge clk); #1;
      wr_write = 1'b0;
      @(negedge clk);
      chk("coll1_rd_next", 256'(rd_wait), 256'(0));
      model_rd(rd_addr, rd_bc, cyc);
      @(posedge clk); #1;
      wr_addr = WIN | 28'h420; wr_wdata = wdat(9, 0); wr_write = 1'b1;
      @(negedge clk);
      chk("coll_rdissue_waits", 256'({rd_wait, wr_wait}), 256'(2'b11));
      @(posedge clk); #1;
      @(negedge clk);
      chk("coll2_grant", 256'({rd_wait, wr_wait}), 256'(2'b01));
      model_rd(rd_addr, rd_bc, cyc);
      @(posedge clk); #1;
      rd_read = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("coll2_wr_after", 256'(wr_wait), 256'(0));
      mem_m[33] = wr_wdata;
      @(posedge clk); #1;
      wr_write = 1'b0;
      do_read(WIN | 28'h420, 6'd1);
      drain();

      // 4-beat write/read, then a full 32-beat burst at word 0.
      do_write(WIN | 28'h40, 6'd4, 0);
      do_read(WIN | 28'h40, 6'd4);
      drain();
      do_write(WIN, 6'd32, 32'h5a5a);
      do_read(WIN, 6'd32);
      drain();
      chk_err("err_clean");

      // Wrap across the top of RAM.
      do_write(WIN | (28'hFFE << 5), 6'd3, 32'hbeef);
      do_read(WIN | (28'hFFE << 5), 6'd3);
      do_read(WIN, 6'd1);
      drain();

      // Random traffic, back-to-back commands with beats in flight.
      for (int it = 0; it < 16; it++) begin
         a    = {3'b001, 8'($urandom), 12'($urandom), 5'($urandom)};
         bc   = 6'($urandom_range(1, 32));
         seed = int'($urandom);
         do_write(a, bc, seed);
         do_read(a, bc);
         do_write(a, 6'($urandom_range(1, 32)), seed + 1);
         do_read(a, bc);
         if (it % 4 == 3) drain();
      end
      drain();
      chk_err("err_after_random");

      // Error cases: zero burst, oversize burst, out-of-window write and read.
      do_write(WIN | 28'h40, 6'd4, 32'h77);
      do_read(WIN | 28'h40, 6'd0);
      drain();
      chk_err("err_bc0");
      do_write(WIN | 28'h800, 6'd40, 32'h1234);
      do_read(WIN | 28'h800, 6'd32);
      drain();
      do_write(28'h400_0040, 6'd2, 32'h99);
      do_read(WIN | 28'h40, 6'd2);
      do_read(28'h400_0040, 6'd3);
      drain();
      chk_err("err_sticky");

      // Reset in the third issue cycle of an 8-beat read.
      do_write(WIN | 28'h1000, 6'd8, 32'h4242);
      do_read(WIN | 28'h1000, 6'd8);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      p = cyc;
      @(negedge clk);
      @(posedge clk); #1;
      exp_d.delete(); exp_due.delete();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("rst_mid_rdv", 256'(rdv), 256'(0));
         chk("rst_mid_waits", 256'({rd_wait, wr_wait}), 256'(2'b11));
         @(posedge clk); #1;
      end
      rst = 1'b0;
      exp_err = 1'b0;
      chk("rst_len", 256'(cyc - p), 256'(3));
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_rdv", 256'(rdv), 256'(0));
         @(posedge clk); #1;
      end
      chk_err("err_cleared");
      do_write(WIN | 28'h1000, 6'd2, 32'h6060);
      do_read(WIN | 28'h1000, 6'd2);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
